// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter onto a registered common data bus.
// Define CDB_ARBITER_STATS_EN to add the bcast_cnt / conflict_cnt statistics outputs.
module cdb_arbiter #(
   parameter int N_PORTS = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    flush,
   input  logic [N_PORTS-1:0]      req,
   input  logic [8*N_PORTS-1:0]    req_tag,
   input  logic [32*N_PORTS-1:0]   req_data,
   output logic [N_PORTS-1:0]      taken,
   output logic [40:0]             cdb
`ifdef CDB_ARBITER_STATS_EN
   ,
   output logic [31:0]             bcast_cnt,
   output logic [31:0]             conflict_cnt
`endif
);
   localparam int PW = $clog2(N_PORTS);
   logic [PW-1:0]      ptr_q, ptr_d, win;
   logic [N_PORTS-1:0] elig;
   logic               found, grant;
   logic [40:0]        cdb_q, cdb_d;
   // Tag 0 means "no producer": such a request is never eligible.
   always_comb begin
      elig = '0;
      for (int i = 0; i < N_PORTS; i++) elig[i] = req[i] && (req_tag[8*i +: 8] != 8'h00);
   end
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < N_PORTS; k++) begin
         if (!found && elig[(int'(ptr_q) + k) % N_PORTS]) begin
            found = 1'b1;
            win   = PW'((int'(ptr_q) + k) % N_PORTS);
         end
      end
   end
   assign grant = found && !flush && !rst;
   assign taken = grant ? N_PORTS'(1) << win : '0;
   always_comb begin
      ptr_d = flush ? '0 : !grant ? ptr_q : (int'(win) == N_PORTS - 1) ? '0 : win + 1'b1;
      cdb_d = grant ? {1'b1, req_tag[8*int'(win) +: 8], req_data[32*int'(win) +: 32]} : '0;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ptr_q <= '0;
         cdb_q <= '0;
      end else begin
         ptr_q <= ptr_d;
         cdb_q <= cdb_d;
      end
   end
   assign cdb = cdb_q;
`ifdef CDB_ARBITER_STATS_EN
   logic [31:0] bcast_cnt_q, bcast_cnt_d, conflict_cnt_q, conflict_cnt_d;
   // A conflict cycle leaves some eligible port without a grant; flush cycles count too.
   always_comb begin
      bcast_cnt_d    = bcast_cnt_q + 32'(grant);
      conflict_cnt_d = conflict_cnt_q + 32'(|(elig & ~taken));
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcast_cnt_q    <= '0;
         conflict_cnt_q <= '0;
      end else begin
         bcast_cnt_q    <= bcast_cnt_d;
         conflict_cnt_q <= conflict_cnt_d;
      end
   end
   assign bcast_cnt    = bcast_cnt_q;
   assign conflict_cnt = conflict_cnt_q;
`endif
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a behavioural model.
module tb_cdb_arbiter;
   localparam int N = 4;
   logic            clk = 1'b0;
   logic            rst, flush;
   logic [N-1:0]    req;
   logic [8*N-1:0]  req_tag;
   logic [32*N-1:0] req_data;
   logic [N-1:0]    taken;
   logic [40:0]     cdb;
`ifdef CDB_ARBITER_STATS_EN
   logic [31:0]     bcast_cnt, conflict_cnt;
`endif
   cdb_arbiter #(.N_PORTS(N)) dut (
      .clk(clk), .rst(rst), .flush(flush), .req(req), .req_tag(req_tag),
      .req_data(req_data), .taken(taken), .cdb(cdb)
`ifdef CDB_ARBITER_STATS_EN
      , .bcast_cnt(bcast_cnt), .conflict_cnt(conflict_cnt)
`endif
   );
   always #5 clk = ~clk;
   int          nvec = 0, nerr = 0;
   int          mptr, last_win;
   logic [40:0] mcdb;
   logic [31:0] mbc, mcc, c0;
   logic [N-1:0] t_seen;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      nvec++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   function automatic bit elig(input int i);
      return req[i] && (req_tag[8*i +: 8] != 8'h00);
   endfunction
   task automatic set_port(input int i, input logic r, input logic [7:0] t, input logic [31:0] d);
      req[i] = r;
      req_tag[8*i +: 8] = t;
      req_data[32*i +: 32] = d;
   endtask
   // One clock cycle: compare at the falling edge, advance the model, return just after the rising edge.
   task automatic tick();
      int w;
      bit miss;
      @(negedge clk);
      w = -1;
      if (!rst && !flush)
         for (int k = 0; k < N; k++)
            if (w < 0 && elig((mptr + k) % N)) w = (mptr + k) % N;
      t_seen = taken;
      chk("taken", 64'(taken), w < 0 ? 64'd0 : 64'd1 << w);
      chk("cdb", 64'(cdb), rst ? 64'd0 : 64'(mcdb));
`ifdef CDB_ARBITER_STATS_EN
      chk("bcast_cnt", 64'(bcast_cnt), rst ? 64'd0 : 64'(mbc));
      chk("conflict_cnt", 64'(conflict_cnt), rst ? 64'd0 : 64'(mcc));
`endif
      miss = 1'b0;
      for (int i = 0; i < N; i++) if (elig(i) && i != w) miss = 1'b1;
      last_win = w;
      if (rst) begin
         mptr = 0;
         mcdb = '0;
         mbc  = '0;
         mcc  = '0;
      end else begin
         mcdb = w < 0 ? 41'd0 : {1'b1, req_tag[8*w +: 8], req_data[32*w +: 32]};
         mptr = flush ? 0 : w < 0 ? mptr : (w + 1) % N;
         mbc  = mbc + 32'(w >= 0);
         mcc  = mcc + 32'(miss);
      end
      @(posedge clk);
      #1;
   endtask
   initial begin
      rst = 1'b0; flush = 1'b0; req = '0; req_tag = '0; req_data = '0;
      mptr = 0; mcdb = '0; mbc = '0; mcc = '0; last_win = -1; c0 = '0;
      #1 rst = 1'b1;
      #1 chk("rst_cdb", 64'(cdb), 64'd0);
      chk("rst_taken", 64'(taken), 64'd0);
      tick(); tick();
      rst = 1'b0;
      tick(); tick(); tick();
      // single request on port 2
      set_port(2, 1'b1, 8'h13, 32'hDEADBEEF);
      tick();
      chk("single_taken", 64'(t_seen), 64'h4);
      chk("single_win", 64'(last_win), 64'd2);
      req[2] = 1'b0;
      chk("single_cdb", 64'(cdb), 64'h1_13_DEADBEEF);
      tick();
      chk("single_cdb_clear", 64'(cdb), 64'd0);
      // full contention starting from ptr 0
      flush = 1'b1;
      tick();
      flush = 1'b0;
`ifdef CDB_ARBITER_STATS_EN
      c0 = conflict_cnt;
`endif
      for (int i = 0; i < N; i++) set_port(i, 1'b1, 8'(i + 1), 32'hA0 + i);
      for (int k = 0; k < N; k++) begin
         tick();
         chk("rr_order", 64'(last_win), 64'(k));
         if (last_win >= 0) req[last_win] = 1'b0;
         chk("rr_tag", 64'(cdb[39:32]), 64'(k + 1));
      end
`ifdef CDB_ARBITER_STATS_EN
      chk("rr_conflicts", 64'(conflict_cnt - c0), 64'd3);
`endif
      // zero tag never wins and never moves the pointer
      set_port(1, 1'b1, 8'h00, 32'h11111111);
      set_port(3, 1'b1, 8'h07, 32'h33333333);
      tick();
      chk("zt_taken", 64'(t_seen), 64'h8);
      req[3] = 1'b0;
      tick();
      chk("zt_idle", 64'(t_seen), 64'h0);
      set_port(0, 1'b1, 8'h05, 32'h0);
      set_port(3, 1'b1, 8'h06, 32'h3);
      tick();
      chk("zt_ptr0", 64'(t_seen), 64'h1);
      req[0] = 1'b0;
      tick();
      chk("zt_p3", 64'(t_seen), 64'h8);
      req = '0;
      // flush right after a grant
      set_port(0, 1'b1, 8'h09, 32'hCAFE0000);
      tick();
      chk("fl_grant", 64'(t_seen), 64'h1);
      req[0] = 1'b0;
      set_port(1, 1'b1, 8'h0A, 32'hCAFE0001);
      flush = 1'b1;
      chk("fl_cdb_live", 64'(cdb), 64'h1_09_CAFE0000);
      tick();
      chk("fl_no_taken", 64'(t_seen), 64'h0);
      flush = 1'b0;
      chk("fl_cdb_zero", 64'(cdb), 64'd0);
      tick();
      chk("fl_after", 64'(t_seen), 64'h2);
      req[1] = 1'b0;
      // asynchronous reset while broadcasting
      set_port(2, 1'b1, 8'h22, 32'h22222222);
      tick();
      req[2] = 1'b0;
      chk("ar_on", 64'(cdb[40]), 64'd1);
      #2 rst = 1'b1;
      #1 chk("ar_cdb", 64'(cdb), 64'd0);
      chk("ar_taken", 64'(taken), 64'd0);
`ifdef CDB_ARBITER_STATS_EN
      chk("ar_bcast", 64'(bcast_cnt), 64'd0);
`endif
      tick();
      rst = 1'b0;
      tick();
`ifdef CDB_ARBITER_STATS_EN
      // broadcast counter wraps from all-ones
      force dut.bcast_cnt_q = 32'hFFFFFFFF;
      #1 release dut.bcast_cnt_q;
      mbc = 32'hFFFFFFFF;
      set_port(0, 1'b1, 8'h44, 32'h44444444);
      tick();
      req[0] = 1'b0;
      chk("wrap_bcast", 64'(bcast_cnt), 64'd0);
      tick();
`endif
      // randomized traffic obeying the unit handshake
      for (int c = 0; c < 3000; c++) begin
         if (last_win >= 0) req[last_win] = 1'b0;
         rst = ($urandom_range(0, 499) == 0);
         if (rst) req = '0;
         else
            for (int i = 0; i < N; i++) begin
               if (!req[i]) begin
                  if ($urandom_range(0, 2) == 0)
                     set_port(i, 1'b1, ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom_range(1, 255)), $urandom);
               end else if (req_tag[8*i +: 8] == 8'h00 && $urandom_range(0, 3) == 0) begin
                  req[i] = 1'b0;
               end
            end
         flush = ($urandom_range(0, 15) == 0);
         tick();
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
